execute_stage: RTL and testbench

//  Y86-64 pipeline execute stage plus E->M pipeline register: ALU, condition-code (CC) register, branch/cmov condition.

---
 rtl/y86_pkg.sv | 100 ++++++++++
 rtl/execute_stage_alu.sv | 44 ++++
 rtl/execute_stage.sv | 129 ++++++++++++
 tb/tb_execute_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the execute stage: instruction, status,
// register, ALU function and condition codes, plus the E->M payload struct.
// Optional feature macro: ALU_EXT_EN (adds OPq or/shl).
package y86_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned STK_INC = 8;

  typedef logic [NIB_W-1:0]  nib_t;
  typedef logic [WORD_W-1:0] word_t;

  // Instruction codes
  localparam nib_t I_HALT   = 4'h0;
  localparam nib_t I_NOP    = 4'h1;
  localparam nib_t I_RRMOVQ = 4'h2;
  localparam nib_t I_IRMOVQ = 4'h3;
  localparam nib_t I_RMMOVQ = 4'h4;
  localparam nib_t I_MRMOVQ = 4'h5;
  localparam nib_t I_OPQ    = 4'h6;
  localparam nib_t I_JXX    = 4'h7;
  localparam nib_t I_CALL   = 4'h8;
  localparam nib_t I_RET    = 4'h9;
  localparam nib_t I_PUSHQ  = 4'hA;
  localparam nib_t I_POPQ   = 4'hB;

  // Status codes
  localparam nib_t S_AOK = 4'h1;
  localparam nib_t S_ADR = 4'h2;
  localparam nib_t S_HLT = 4'h3;
  localparam nib_t S_INS = 4'h4;

  localparam nib_t RNONE = 4'hF;

  // ALU function codes (OPq ifun)
  localparam nib_t A_ADD = 4'h0;
  localparam nib_t A_SUB = 4'h1;
  localparam nib_t A_AND = 4'h2;
  localparam nib_t A_XOR = 4'h3;
  localparam nib_t A_OR  = 4'h4;
  localparam nib_t A_SHL = 4'h5;

  // Branch / cmov condition codes (jXX/cmovXX ifun)
  localparam nib_t C_ALW = 4'h0;
  localparam nib_t C_LE  = 4'h1;
  localparam nib_t C_L   = 4'h2;
  localparam nib_t C_E   = 4'h3;
  localparam nib_t C_NE  = 4'h4;
  localparam nib_t C_GE  = 4'h5;
  localparam nib_t C_G   = 4'h6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // E->M pipeline register payload
  typedef struct packed {
    nib_t  stat;
    nib_t  icode;
    logic  cnd;
    word_t val_e;
    word_t val_a;
    nib_t  dst_e;
    nib_t  dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                                  val_e: '0, val_a: '0,
                                  dst_e: RNONE, dst_m: RNONE};

  // OPq function codes the ALU implements in this build
  function automatic logic opq_fun_legal(input nib_t f);
`ifdef ALU_EXT_EN
    return (f <= A_SHL);
`else
    return (f <= A_XOR);
`endif
  endfunction

  // Branch / cmov condition from the CC register
  function automatic logic cond_eval(input cc_t cc, input nib_t f);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (f)
      C_ALW:   return 1'b1;
      C_LE:    return lt | cc.zf;
      C_L:     return lt;
      C_E:     return cc.zf;
      C_NE:    return ~cc.zf;
      C_GE:    return ~lt;
      C_G:     return ~lt & ~cc.zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Y86-64 ALU: result = b <op> a, with zero/sign/overflow flags.
// Pure combinational.
// Ports: a, b operands; fun function code; result; zf, sf, of flags.
// Optional feature macro: ALU_EXT_EN (fun 4 = or, fun 5 = b shl a[5:0]).
module alu
  import y86_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [NIB_W-1:0]  fun,
  output logic [WORD_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int unsigned MSB = WORD_W - 1;

  // Function select and flag generation
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      A_ADD: begin
        result = b + a;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      A_SUB: begin
        result = b - a;
        of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      A_AND: result = b & a;
      A_XOR: result = b ^ a;
`ifdef ALU_EXT_EN
      A_OR:  result = b | a;
      A_SHL: result = b << a[5:0];
`endif
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[MSB];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage and E->M pipeline register.
// Selects ALU operands by icode, holds the CC register, evaluates the
// branch/cmov condition and registers results into the M stage.
// Ports:
//   clock, reset (synchronous, active-high)
//   E_* : decoded instruction fields entering execute
//   M_bubble : insert a bubble into M; m_stat/W_stat : downstream status
//   e_valE, e_dstE : combinational, for decode forwarding
//   M_* : registered outputs to the memory stage
// Optional feature macro: ALU_EXT_EN (OPq or/shl become legal).
module execute_stage
  import y86_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [NIB_W-1:0]  E_stat,
  input  logic [NIB_W-1:0]  E_icode,
  input  logic [NIB_W-1:0]  E_ifun,
  input  logic [WORD_W-1:0] E_valC,
  input  logic [WORD_W-1:0] E_valA,
  input  logic [WORD_W-1:0] E_valB,
  input  logic [NIB_W-1:0]  E_dstE,
  input  logic [NIB_W-1:0]  E_dstM,
  input  logic              M_bubble,
  input  logic [NIB_W-1:0]  m_stat,
  input  logic [NIB_W-1:0]  W_stat,
  output logic [WORD_W-1:0] e_valE,
  output logic [NIB_W-1:0]  e_dstE,
  output logic [NIB_W-1:0]  M_stat,
  output logic [NIB_W-1:0]  M_icode,
  output logic [NIB_W-1:0]  M_dstE,
  output logic [NIB_W-1:0]  M_dstM,
  output logic [WORD_W-1:0] M_valE,
  output logic [WORD_W-1:0] M_valA,
  output logic              M_Cnd
);

  word_t  alu_a;
  word_t  alu_b;
  nib_t   alu_fun;
  word_t  alu_res;
  cc_t    alu_cc;
  cc_t    cc;
  m_reg_t m_reg;
  m_reg_t m_next;
  logic   e_cnd;
  logic   instr_ok;
  logic   set_cc;

  // ALU operand and function selection
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = A_ADD;
    case (E_icode)
      I_RRMOVQ: alu_a = E_valA;
      I_IRMOVQ: alu_a = E_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = E_valC;
        alu_b = E_valB;
      end
      I_OPQ: begin
        alu_a   = E_valA;
        alu_b   = E_valB;
        alu_fun = E_ifun;
      end
      I_CALL, I_PUSHQ: begin
        alu_a   = WORD_W'(STK_INC);
        alu_b   = E_valB;
        alu_fun = A_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = WORD_W'(STK_INC);
        alu_b = E_valB;
      end
      default: ;
    endcase
  end

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fun    (alu_fun),
    .result (alu_res),
    .zf     (alu_cc.zf),
    .sf     (alu_cc.sf),
    .of     (alu_cc.of)
  );

  // Legality, condition and forwarding outputs
  always_comb begin
    instr_ok = (E_icode <= I_POPQ) && !((E_icode == I_OPQ) && !opq_fun_legal(E_ifun));
    // Condition uses the registered CC, so an OPq in E never sees its own flags
    e_cnd    = cond_eval(cc, E_ifun);
    // Failed cmov suppresses the register write
    e_dstE   = ((E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : E_dstE;
    e_valE   = alu_res;
    // Exceptions downstream freeze the architectural flags
    set_cc   = (E_icode == I_OPQ) && instr_ok && (E_stat == S_AOK) &&
               (m_stat == S_AOK) && (W_stat == S_AOK);
    m_next   = '{stat:  instr_ok ? E_stat : S_INS,
                 icode: E_icode,
                 cnd:   e_cnd,
                 val_e: alu_res,
                 val_a: E_valA,
                 dst_e: e_dstE,
                 dst_m: E_dstM};
  end

  // CC register and E->M pipeline register; reset dominates bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      cc    <= CC_RST;
      m_reg <= M_BUBBLE;
    end else begin
      if (set_cc) cc <= alu_cc;
      m_reg <= M_bubble ? M_BUBBLE : m_next;
    end
  end

  assign M_stat  = m_reg.stat;
  assign M_icode = m_reg.icode;
  assign M_dstE  = m_reg.dst_e;
  assign M_dstM  = m_reg.dst_m;
  assign M_valE  = m_reg.val_e;
  assign M_valA  = m_reg.val_a;
  assign M_Cnd   = m_reg.cnd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed test of execute_stage: ALU results, CC update/suppression,
// condition evaluation, cmov dstE suppression, bubble and reset behaviour.
// Honours ALU_EXT_EN the same way as the RTL.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd;

  int n_checks = 0;
  int n_errors = 0;

  execute_stage dut (
    .clock(clock), .reset(reset),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .M_bubble(M_bubble), .m_stat(m_stat), .W_stat(W_stat),
    .e_valE(e_valE), .e_dstE(e_dstE),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .M_valA(M_valA), .M_Cnd(M_Cnd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] de,
                       input logic [3:0] dm);
    E_icode = icode; E_ifun = ifun;
    E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = de; E_dstM = dm;
    #1;
  endtask

  // Observe CC through cmov: cmove exposes ZF, cmovl exposes SF^OF
  task automatic probe_cc(input string tag, input logic zf, input logic lt);
    drive(4'h2, 4'h3, 64'h0, 64'h0, 64'h0, 4'h2, 4'hF);
    check({tag, "_zf"}, 64'(e_dstE), zf ? 64'h2 : 64'hF);
    drive(4'h2, 4'h2, 64'h0, 64'h0, 64'h0, 4'h2, 4'hF);
    check({tag, "_lt"}, 64'(e_dstE), lt ? 64'h2 : 64'hF);
  endtask

  initial begin
    reset = 1'b1; M_bubble = 1'b0;
    E_stat = 4'h1; m_stat = 4'h1; W_stat = 4'h1;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    step(); step();

    // Reset state
    check("rst_icode", 64'(M_icode), 64'h1);
    check("rst_stat",  64'(M_stat),  64'h1);
    check("rst_dstE",  64'(M_dstE),  64'hF);
    check("rst_dstM",  64'(M_dstM),  64'hF);
    check("rst_valE",  M_valE, 64'h0);
    check("rst_cnd",   64'(M_Cnd), 64'h0);
    probe_cc("rst_cc", 1'b1, 1'b0);
    reset = 1'b0;

    // OPq sub: 3 - 5
    drive(4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h3, 4'hF);
    check("sub_evalE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check("sub_MvalE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_Micode", 64'(M_icode), 64'h6);
    check("sub_MdstE", 64'(M_dstE), 64'h3);
    probe_cc("sub_cc", 1'b0, 1'b1);

    // OPq add overflow: 0x7FFF..FF + 1 -> SF=1, OF=1
    drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, 4'hF);
    check("addov_evalE", e_valE, 64'h8000_0000_0000_0000);
    step();
    probe_cc("addov_cc", 1'b0, 1'b0);
    drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    step();
    check("jl_cnd", 64'(M_Cnd), 64'h0);
    check("jl_icode", 64'(M_icode), 64'h7);
    drive(4'h7, 4'h5, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    step();
    check("jge_cnd", 64'(M_Cnd), 64'h1);

    // and / xor
    drive(4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0, 4'h1, 4'hF);
    check("and_evalE", e_valE, 64'h30);
    drive(4'h6, 4'h3, 64'hF0, 64'h3C, 64'h0, 4'h1, 4'hF);
    check("xor_evalE", e_valE, 64'hCC);

    // add 1+1 -> CC all clear; cmovle then fails
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h1, 4'hF);
    step();
    drive(4'h2, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h4, 4'hF);
    check("cmovle_edstE", 64'(e_dstE), 64'hF);
    check("cmovle_evalE", e_valE, 64'h1234);
    step();
    check("cmovle_cnd", 64'(M_Cnd), 64'h0);
    check("cmovle_MdstE", 64'(M_dstE), 64'hF);

    // Downstream exceptions block the CC load
    m_stat = 4'h2;
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h1, 4'hF);
    step();
    check("madr_Mstat", 64'(M_stat), 64'h1);
    m_stat = 4'h1;
    probe_cc("madr_cc", 1'b0, 1'b0);
    W_stat = 4'h3;
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h1, 4'hF);
    step();
    W_stat = 4'h1;
    probe_cc("whlt_cc", 1'b0, 1'b0);
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h1, 4'hF);
    step();
    probe_cc("zero_cc", 1'b1, 1'b0);

    // Address / stack arithmetic and valA pass-through
    drive(4'h4, 4'h0, 64'hAA, 64'h100, 64'h20, 4'hF, 4'h7);
    check("rmmov_evalE", e_valE, 64'h120);
    step();
    check("rmmov_MvalA", M_valA, 64'hAA);
    check("rmmov_MdstM", 64'(M_dstM), 64'h7);
    drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 4'h2, 4'hF);
    check("irmov_evalE", e_valE, 64'h55);
    drive(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF);
    check("call_evalE", e_valE, 64'h1F8);
    drive(4'hB, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'h3);
    check("popq_evalE", e_valE, 64'h208);
    drive(4'h0, 4'h0, 64'h9, 64'h200, 64'h9, 4'hF, 4'hF);
    check("halt_evalE", e_valE, 64'h0);

    // Status propagation and illegal icode
    E_stat = 4'h2;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    step();
    check("adr_Mstat", 64'(M_stat), 64'h2);
    E_stat = 4'h1;
    drive(4'hC, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    step();
    check("badicode_Mstat", 64'(M_stat), 64'h4);

    // Clear CC, then OPq ifun 4
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'h0, 4'h1, 4'hF);
    step();
    drive(4'h6, 4'h4, 64'hF0, 64'h0F, 64'h0, 4'h1, 4'hF);
    step();
`ifdef ALU_EXT_EN
    check("or_Mstat", 64'(M_stat), 64'h1);
    check("or_MvalE", M_valE, 64'hFF);
    probe_cc("or_cc", 1'b0, 1'b0);
    drive(4'h6, 4'h5, 64'h44, 64'h1, 64'h0, 4'h1, 4'hF);
    check("shl_evalE", e_valE, 64'h10);
`else
    check("ifun4_Mstat", 64'(M_stat), 64'h4);
    probe_cc("ifun4_cc", 1'b0, 1'b0);
    drive(4'h6, 4'h5, 64'h44, 64'h1, 64'h0, 4'h1, 4'hF);
    step();
    check("ifun5_Mstat", 64'(M_stat), 64'h4);
`endif

    // Bubble into M
    M_bubble = 1'b1;
    drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h77, 4'h2, 4'h5);
    step();
    M_bubble = 1'b0;
    check("bub_icode", 64'(M_icode), 64'h1);
    check("bub_dstE", 64'(M_dstE), 64'hF);
    check("bub_valE", M_valE, 64'h0);

    // Reset mid-operation beats a legal OPq in E
    drive(4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h1, 4'hF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_icode", 64'(M_icode), 64'h1);
    check("midrst_valE", M_valE, 64'h0);
    probe_cc("midrst_cc", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
